// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, opcode/funct constants and decoded-beat struct
package alu_pkg;

    // ALU control codes presented to the execute stage
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLTU    = 4'b1000;
    localparam logic [3:0] ALU_SLL     = 4'b1001;
    localparam logic [3:0] ALU_SRA     = 4'b1010;
    localparam logic [3:0] ALU_SRL     = 4'b1011;
    localparam logic [3:0] ALU_XOR     = 4'b1101;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Operand selects produced by the decoder
    localparam logic [1:0] B_SEL_REG  = 2'd0;
    localparam logic [1:0] B_SEL_SEXT = 2'd1;
    localparam logic [1:0] B_SEL_ZEXT = 2'd2;
    localparam logic       A_SEL_RS   = 1'b0;
    localparam logic       A_SEL_RT   = 1'b1;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr_en;
        logic        illegal;
    } beat_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational opcode/funct decoder for the ALU issue stage
// Ports:
//   instr    in  32  instruction word
//   alu_ctrl out 4   ALU control code (1111 when undecodable)
//   b_sel    out 2   operand B source: register / sign-extended / zero-extended immediate
//   a_sel    out 1   operand A source: rs / rt
//   rd       out 5   destination register
//   wr_en    out 1   register write enable
//   illegal  out 1   instruction is not decodable
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  b_sel,
    output logic        a_sel,
    output logic [4:0]  rd,
    output logic        wr_en,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // rs index and shamt are not needed here: operands arrive as data, and
    // shamt reaches the ALU through the sign-extended immediate on B.
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        alu_ctrl = ALU_ILLEGAL;
        b_sel    = B_SEL_REG;
        a_sel    = A_SEL_RS;
        rd       = '0;
        wr_en    = 1'b0;
        illegal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                rd      = instr[15:11];
                wr_en   = 1'b1;
                illegal = 1'b0;
                case (funct)
                    FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:          alu_ctrl = ALU_AND;
                    FN_OR:           alu_ctrl = ALU_OR;
                    FN_XOR:          alu_ctrl = ALU_XOR;
                    FN_SLT:          alu_ctrl = ALU_SLT;
                    FN_SLTU:         alu_ctrl = ALU_SLTU;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        alu_ctrl = (funct == FN_SLL) ? ALU_SLL :
                                   (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                        a_sel    = A_SEL_RT;
                        b_sel    = B_SEL_SEXT;
                    end
                    default: begin
                        rd      = '0;
                        wr_en   = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
                alu_ctrl = (opcode == OP_SLTI)  ? ALU_SLT  :
                           (opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
                b_sel    = B_SEL_SEXT;
                rd       = instr[20:16];
                wr_en    = 1'b1;
                illegal  = 1'b0;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                alu_ctrl = (opcode == OP_ANDI) ? ALU_AND :
                           (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                b_sel    = B_SEL_ZEXT;
                rd       = instr[20:16];
                wr_en    = 1'b1;
                illegal  = 1'b0;
            end
            OP_SW: begin
                alu_ctrl = ALU_ADD;
                b_sel    = B_SEL_SEXT;
                illegal  = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                alu_ctrl = ALU_SUB;
                illegal  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue stage: decode, operand select and registered ID/EX handshake
// Build option: ALU_ISSUE_SKID_EN adds a skid register behind the output register
// (registered o_ready); without it a single output register is used.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_valid / o_ready      upstream handshake
//   i_instr                instruction word
//   i_rs_data, i_rt_data   GPR[rs], GPR[rt]
//   i_flush                discard all held and incoming beats
//   o_valid / i_ready      downstream (execute) handshake
//   o_ALUctrl, o_A, o_B    ALU control code and operands
//   o_rd, o_wr_en          destination register and write enable
//   o_illegal              instruction is not decodable
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [3:0]        o_ALUctrl,
    output logic [DATA_W-1:0] o_A,
    output logic [DATA_W-1:0] o_B,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_wr_en,
    output logic              o_illegal
);

    logic [3:0] dec_alu_ctrl;
    logic [1:0] dec_b_sel;
    logic       dec_a_sel;
    logic [4:0] dec_rd;
    logic       dec_wr_en;
    logic       dec_illegal;

    alu_ctrl_dec u_dec (
        .instr    (i_instr),
        .alu_ctrl (dec_alu_ctrl),
        .b_sel    (dec_b_sel),
        .a_sel    (dec_a_sel),
        .rd       (dec_rd),
        .wr_en    (dec_wr_en),
        .illegal  (dec_illegal)
    );

    beat_t in_beat;
    beat_t m_beat;
    logic  m_valid;
    logic  accept;

    // Undecodable beats carry zero operands so nothing stale leaks downstream.
    always_comb begin
        in_beat          = '0;
        in_beat.alu_ctrl = dec_alu_ctrl;
        in_beat.rd       = dec_rd;
        in_beat.wr_en    = dec_wr_en;
        in_beat.illegal  = dec_illegal;
        if (!dec_illegal) begin
            in_beat.a = (dec_a_sel == A_SEL_RT) ? i_rt_data : i_rs_data;
            case (dec_b_sel)
                B_SEL_SEXT: in_beat.b = {{16{i_instr[15]}}, i_instr[15:0]};
                B_SEL_ZEXT: in_beat.b = {16'h0000, i_instr[15:0]};
                default:    in_beat.b = i_rt_data;
            endcase
        end
    end

    assign accept = i_valid && o_ready;

`ifdef ALU_ISSUE_SKID_EN
    beat_t s_beat;
    logic  s_valid;

    assign o_ready = !s_valid;

    // Skid only fills while the main register is stalled, and always drains
    // into main before upstream is allowed to send again.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_valid <= 1'b0;
            m_beat  <= '0;
            s_valid <= 1'b0;
            s_beat  <= '0;
        end else if (i_flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!m_valid || i_ready) begin
            if (s_valid) begin
                m_beat  <= s_beat;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else begin
                m_valid <= accept;
                if (accept) begin
                    m_beat <= in_beat;
                end
            end
        end else if (accept) begin
            s_beat  <= in_beat;
            s_valid <= 1'b1;
        end
    end
`else
    assign o_ready = !m_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_valid <= 1'b0;
            m_beat  <= '0;
        end else if (i_flush) begin
            m_valid <= 1'b0;
        end else if (accept) begin
            m_beat  <= in_beat;
            m_valid <= 1'b1;
        end else if (i_ready) begin
            m_valid <= 1'b0;
        end
    end
`endif

    assign o_valid   = m_valid;
    assign o_ALUctrl = m_beat.alu_ctrl;
    assign o_A       = m_beat.a;
    assign o_B       = m_beat.b;
    assign o_rd      = m_beat.rd;
    assign o_wr_en   = m_beat.wr_en;
    assign o_illegal = m_beat.illegal;

endmodule
